gpio_out_port: RTL
==================

Name: gpio_out_port

Overview:
- Parametrised successor to the 8-bit latched output port: a WIDTH-bit registered output register with write/set/clear/toggle modes.
- Adds a one-shot timed pulse engine that inverts a bit mask for a programmed number of cycles and then restores it.
- Sits on the CPU's memory-mapped I/O bus; drives board pins (LEDs, strobes, chip selects).
- Provides registered readback so software can read the pin state.

Parameters:
- WIDTH, 8, number of output lines.
- PULSE_BITS, 16, width of the pulse length counter.
- RESET_VALUE, 0, value of out_lines after reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- write_data  input  WIDTH  data for WRITE; bit mask for SET/CLEAR/TOGGLE and for pulse.
- write_mode  input  2  00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE.
- write_enable  input  1  applies write_mode with write_data this cycle.
- pulse_start  input  1  requests a timed pulse on the bits in write_data.
- pulse_len  input  PULSE_BITS  pulse length in cycles; 0 is treated as 1.
- out_lines  output  WIDTH  registered output lines.
- read_data  output  WIDTH  equals out_lines; combinational copy for bus readback.
- busy  output  1  high while a pulse is in progress.
- pulse_ack  output  1  one-cycle strobe: pulse_start was accepted.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge, overrides everything:
  - out_lines=RESET_VALUE; busy=0; pulse_ack=0; counter=0; stored mask=0.
  - Reset during a pulse aborts it with no restore toggle.
- Write modes, result visible on out_lines one cycle after the edge:
  - WRITE: out = write_data.
  - SET: out = out | write_data.
  - CLEAR: out = out & ~write_data.
  - TOGGLE: out = out ^ write_data.
- Pulse acceptance:
  - Condition: pulse_start=1, busy=0 and write_enable=0.
  - Effect: out = out ^ write_data; mask = write_data; counter = max(pulse_len,1); busy=1; pulse_ack=1 for exactly one cycle.
- Pulse rejection:
  - pulse_start while busy=1 is ignored, with no ack.
  - pulse_start together with write_enable=1 is ignored, with no ack; write_enable has priority.
- Counting:
  - While busy, counter decrements by 1 each cycle.
  - On the cycle where counter==1: out = out ^ mask; busy=0; counter=0.
  - Masked bits therefore differ from their pre-pulse value for exactly N cycles (N = max(pulse_len,1)).
- Mask of 0: the pulse is still accepted and times out normally; busy is high for N cycles and out_lines are unchanged.
- Write during a pulse is allowed:
  - If a write and the expiry land on the same cycle, the restore toggle is applied to the write result: out = f(write) ^ mask.
  - Software rewriting pulsed bits mid-pulse gets the toggle on top of its write; this is intended.
- Maximum length: pulse_len = 2^PULSE_BITS-1 is supported; the counter never wraps.
- A new pulse can be accepted on the cycle after busy falls.
- Only out_lines, busy, pulse_ack, counter and mask are registered; read_data adds no latency.

Test Plan (WIDTH=8, PULSE_BITS=16, RESET_VALUE=0):
- Modes:
  - rst=1 for 2 cycles -> out_lines=0x00, busy=0.
  - WRITE 0xA5 -> 0xA5; SET 0x0F -> 0xAF; CLEAR 0x81 -> 0x2E; TOGGLE 0xFF -> 0xD1.
- Basic pulse:
  - out=0x00; pulse_start with mask 0x03, pulse_len=4 -> pulse_ack high for 1 cycle.
  - out_lines=0x03 for exactly 4 cycles, then 0x00; busy high for exactly those 4 cycles.
- Zero length and rejection:
  - pulse_len=0, mask 0x80 -> 0x80 for 1 cycle, then restored.
  - pulse_start while busy -> no ack; the pulse still ends at its original time.
  - pulse_start with write_enable in the same cycle -> write applied, no ack.
- Write collision:
  - Pulse mask 0x01, len 3 from out=0x00.
  - WRITE 0xF0 on the expiry cycle -> out_lines=0xF1 afterwards.
  - SET 0x10 on the 2nd pulse cycle -> out becomes 0x11, then 0x10 after expiry.
- Reset mid-pulse:
  - Pulse mask 0xFF, len 100; assert rst at cycle 10 -> out_lines=0x00, busy=0.
  - No toggle at cycle 100.
- Long pulse:
  - pulse_len=0xFFFF -> busy for exactly 65535 cycles; counter does not wrap.

Source files
------------

// File: rtl/gpio_out_port.sv
// Registered WIDTH-bit output port with write/set/clear/toggle modes and a one-shot
// pulse engine that inverts a bit mask for a programmed number of cycles.
module gpio_out_port #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     PULSE_BITS  = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [1:0]            write_mode,
  input  logic                  write_enable,
  input  logic                  pulse_start,
  input  logic [PULSE_BITS-1:0] pulse_len,
  output logic [WIDTH-1:0]      out_lines,
  output logic [WIDTH-1:0]      read_data,
  output logic                  busy,
  output logic                  pulse_ack
);

  localparam logic [1:0] ModeWrite  = 2'b00;
  localparam logic [1:0] ModeSet    = 2'b01;
  localparam logic [1:0] ModeClear  = 2'b10;
  localparam logic [1:0] ModeToggle = 2'b11;

  localparam logic [PULSE_BITS-1:0] CntOne = PULSE_BITS'(1);

  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [PULSE_BITS-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  accept;

  assign accept = pulse_start && !busy_q && !write_enable;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ack_d  = 1'b0;

    if (write_enable) begin
      case (write_mode)
        ModeWrite:  out_d = write_data;
        ModeSet:    out_d = out_q | write_data;
        ModeClear:  out_d = out_q & ~write_data;
        ModeToggle: out_d = out_q ^ write_data;
        default:    out_d = out_q;
      endcase
    end

    if (accept) begin
      out_d  = out_q ^ write_data;
      mask_d = write_data;
      cnt_d  = (pulse_len == '0) ? CntOne : pulse_len;
      busy_d = 1'b1;
      ack_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CntOne) begin
        // Restore lands on top of any same-cycle write result.
        out_d  = out_d ^ mask_q;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RESET_VALUE;
      mask_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
    end
  end

  assign out_lines = out_q;
  assign read_data = out_q;
  assign busy      = busy_q;
  assign pulse_ack = ack_q;

endmodule
